// File: rtl/bcd_display_pkg.sv
// Shared constants and BCD helpers for the six-digit display counter.
// Imported by bcd_display_counter and bcd_digit_cell.
package bcd_display_pkg;

    localparam int DIGITS_DEFAULT = 6;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

    // Out-of-range nibbles (A..F) saturate to 9 so the display never shows a non-decimal digit.
    function automatic bcd_t bcd_clamp(input bcd_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down ripple chain: steps by one when enabled with an incoming carry/borrow
// and reports its own wrap (9->0 up, 0->9 down) to the next digit.
module bcd_digit_cell
    import bcd_display_pkg::*;
(
    input  logic [3:0] cur,
    input  logic       up,
    input  logic       en,
    input  logic       cin,
    output logic [3:0] nxt,
    output logic       cout
);

    logic w_wrap;
    logic w_step;

    assign w_wrap = up ? (cur == BCD_MAX) : (cur == BCD_ZERO);
    assign w_step = en & cin;

    always_comb begin
        nxt = cur;
        if (w_step) begin
            if (up) begin
                nxt = w_wrap ? BCD_ZERO : cur + 4'd1;
            end else begin
                nxt = w_wrap ? BCD_MAX : cur - 4'd1;
            end
        end
    end

    assign cout = w_step & w_wrap;

endmodule

// File: rtl/bcd_display_counter.sv
// Six-digit BCD up/down event counter feeding the 7-segment decoders; counts on prescaler tick or
// debounced button press, with parallel load. Optional leading-zero blanking: LEADING_ZERO_BLANK_EN.
module bcd_display_counter
    import bcd_display_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 10,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int DIGITS       = DIGITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step_n,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  carry
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV + 1);
    localparam int DW       = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);

    // ---------------- prescaler ----------------
    logic [PW-1:0] r_presc;
    logic          w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (!run || (r_presc == PRESC_LAST)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_tick = run & (r_presc == PRESC_LAST);

    // ---------------- synchroniser + debouncer ----------------
    // Synchroniser and debounced level reset to the released (high) state so that
    // deasserting reset can never look like a press.
    logic [1:0]    r_sync;
    logic          r_db;
    logic          r_db_d;
    logic [DW-1:0] r_db_cnt;
    logic          w_step_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= 2'b11;
            r_db     <= 1'b1;
            r_db_d   <= 1'b1;
            r_db_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], step_n};
            r_db_d <= r_db;
            if (r_sync[1] == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db     <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    assign w_step_pulse = r_db_d & ~r_db;

    // ---------------- digit chain ----------------
    logic                w_count_evt;
    logic [4*DIGITS-1:0] r_digits;
    logic [4*DIGITS-1:0] w_chain_digits;
    logic [4*DIGITS-1:0] w_load_clamped;
    logic [4*DIGITS-1:0] w_next_digits;
    logic [DIGITS-1:0]   w_cin;
    logic [DIGITS-1:0]   w_cout;
    logic                r_carry;

    // A tick and a press in the same cycle merge into a single count.
    assign w_count_evt = w_tick | w_step_pulse;
    assign w_cin[0]    = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi > 0) begin : g_chain
                assign w_cin[gi] = w_count_evt & w_cout[gi-1];
            end
            bcd_digit_cell u_cell (
                .cur  (r_digits[4*gi +: 4]),
                .up   (up),
                .en   (w_count_evt),
                .cin  (w_cin[gi]),
                .nxt  (w_chain_digits[4*gi +: 4]),
                .cout (w_cout[gi])
            );
        end
    endgenerate

    always_comb begin
        w_load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
        end
    end

    assign w_next_digits = load ? w_load_clamped : w_chain_digits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits <= '0;
            r_carry  <= 1'b0;
        end else begin
            r_digits <= w_next_digits;
            r_carry  <= ~load & w_cout[DIGITS-1];
        end
    end

    assign digits = r_digits;
    assign carry  = r_carry;

    // ---------------- blanking ----------------
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    logic [DIGITS-1:0] w_blank_nxt;
    logic [DIGITS-1:0] r_blank;
    logic              w_upper_zero;

    // Scan from the most significant digit down; digit 0 is always shown.
    always_comb begin
        w_blank_nxt  = '0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_upper_zero   = w_upper_zero & (w_next_digits[4*i +: 4] == BCD_ZERO);
            w_blank_nxt[i] = w_upper_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank <= BLANK_RST;
        end else begin
            r_blank <= w_blank_nxt;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

endmodule
